// File: rtl/pipeline_stall_ctrl.sv
// Purpose: per-stage enables/flushes for the 5-stage pipe from halt, cache-stall and mispredict requests.
// Latency: 0 cycles request-to-response; state changes 1 cycle. Backpressure: dcache_stall freezes every stage.
// Optional RENAS_STALL_CNT_EN adds saturating stall/bubble/redirect performance counters.
module pipeline_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       FW_halt,
    input  logic       icache_stall,
    input  logic       dcache_stall,
    input  logic       br_mispredict,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       pc_redirect,
    output logic [1:0] ctrl_state,
    output logic       hz_err
`ifdef RENAS_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt_perf
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    state_t     state_q, state_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic       halt_q, halt_d;
    logic       hz_err_q, hz_err_set;
    logic       bubble;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= 3'd0;
            halt_q      <= 1'b0;
            hz_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            halt_q      <= halt_d;
            hz_err_q    <= hz_err_q | hz_err_set;
        end
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_redirect  = 1'b0;
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        halt_d       = 1'b0;
        hz_err_set   = 1'b0;
        bubble       = 1'b0;

        if (dcache_stall) begin
            // Full freeze outranks everything; an in-progress flush just pauses.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            if (state_q != FLUSH)
                state_d = MEM_WAIT;
        end else if (state_q == FLUSH) begin
            if_id_flush = 1'b1;
            if (br_mispredict) begin
                pc_redirect = 1'b1;
                id_ex_flush = 1'b1;
                if (FLUSH_CYCLES > 0)
                    flush_cnt_d = FLUSH_RELOAD;
                else
                    state_d = RUN;
            end else if (flush_cnt_q == 3'd0) begin
                state_d = RUN;
            end else begin
                flush_cnt_d = flush_cnt_q - 3'd1;
            end
        end else begin
            // RUN, or the MEM_WAIT cycle in which the D-cache releases.
            state_d = RUN;
            if (FW_halt) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
                halt_d       = 1'b1;
                hz_err_set   = halt_q;
                bubble       = 1'b1;
            end else if (br_mispredict) begin
                pc_redirect = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (FLUSH_CYCLES > 0) begin
                    flush_cnt_d = FLUSH_RELOAD;
                    state_d     = FLUSH;
                end
            end else if (icache_stall) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign ctrl_state = state_q;
    assign hz_err     = hz_err_q;

`ifdef RENAS_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt      <= '0;
            bubble_cnt     <= '0;
            flush_cnt_perf <= '0;
        end else begin
            if (state_q == MEM_WAIT && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (bubble && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 1'b1;
            if (pc_redirect && flush_cnt_perf != '1)
                flush_cnt_perf <= flush_cnt_perf + 1'b1;
        end
    end
`else
    // Keeps CNT_W referenced when the counters are compiled out.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized and directed bench for pipeline_stall_ctrl against a behavioural stage-control model.
module tb_pipeline_stall_ctrl;

    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic FW_halt = 1'b0, icache_stall = 1'b0, dcache_stall = 1'b0, br_mispredict = 1'b0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect;
    logic [1:0] ctrl_state;
    logic hz_err;
`ifdef RENAS_STALL_CNT_EN
    logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt_perf;
`endif

    pipeline_stall_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .FW_halt(FW_halt), .icache_stall(icache_stall),
        .dcache_stall(dcache_stall), .br_mispredict(br_mispredict),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .pc_redirect(pc_redirect),
        .ctrl_state(ctrl_state), .hz_err(hz_err)
`ifdef RENAS_STALL_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt_perf(flush_cnt_perf)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: remaining wrong-path fetch slots, waiting-on-dcache flag, halt history.
    int flush_left, nxt_flush_left;
    bit waiting, nxt_waiting;
    bit prev_halt, nxt_prev_halt;
    bit err, nxt_err;
    int m_stall, m_bubble, m_redir;
    bit bub_now;
    // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect}
    logic [8:0] exp_out;
    localparam logic [8:0] ALL_RUN = 9'b11111_0000;

    function automatic int exp_state();
        if (flush_left > 0) return 2;
        if (waiting) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        flush_left = 0; waiting = 0; prev_halt = 0; err = 0;
        m_stall = 0; m_bubble = 0; m_redir = 0;
    endtask

    task automatic model_eval(input bit h, input bit ic, input bit dc, input bit br);
        exp_out = ALL_RUN;
        nxt_flush_left = flush_left;
        nxt_waiting = waiting;
        nxt_prev_halt = 0;
        nxt_err = err;
        bub_now = 0;
        if (dc) begin
            exp_out = 9'b0;
            if (flush_left == 0) nxt_waiting = 1;
        end else if (flush_left > 0) begin
            if (br) begin
                exp_out = 9'b11111_1101;
                nxt_flush_left = FC;
            end else begin
                exp_out = 9'b11111_1000;
                nxt_flush_left = flush_left - 1;
            end
        end else begin
            nxt_waiting = 0;
            if (h) begin
                exp_out = 9'b00011_0010;
                nxt_prev_halt = 1;
                bub_now = 1;
                if (prev_halt) nxt_err = 1;
            end else if (br) begin
                exp_out = 9'b11111_1101;
                nxt_flush_left = FC;
            end else if (ic) begin
                exp_out = 9'b00111_0100;
            end
        end
    endtask

    task automatic model_commit();
        if (exp_state() == 1 && m_stall < CMAX) m_stall++;
        if (bub_now && m_bubble < CMAX) m_bubble++;
        if (exp_out[0] && m_redir < CMAX) m_redir++;
        flush_left = nxt_flush_left;
        waiting = nxt_waiting;
        prev_halt = nxt_prev_halt;
        err = nxt_err;
    endtask

    function automatic logic [8:0] dut_out();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect};
    endfunction

    // One clock: drive, check mid-cycle against the model, then advance the model at the edge.
    task automatic cyc(input bit h, input bit ic, input bit dc, input bit br);
        FW_halt = h; icache_stall = ic; dcache_stall = dc; br_mispredict = br;
        @(negedge clk);
        model_eval(h, ic, dc, br);
        chk("outputs", 32'(dut_out()), 32'(exp_out));
        chk("ctrl_state", 32'(ctrl_state), 32'(exp_state()));
        chk("hz_err", 32'(hz_err), 32'(err));
`ifdef RENAS_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bubble));
        chk("flush_cnt_perf", 32'(flush_cnt_perf), 32'(m_redir));
`endif
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        FW_halt = 0; icache_stall = 0; dcache_stall = 0; br_mispredict = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_state", 32'(ctrl_state), 32'd0);
        chk("rst_outputs", 32'(dut_out()), 32'(ALL_RUN));
        chk("rst_hz_err", 32'(hz_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outputs", 32'(dut_out()), 32'(ALL_RUN));
        chk("reset_state", 32'(ctrl_state), 32'd0);
        chk("reset_hz_err", 32'(hz_err), 32'd0);

        // Single load-use halt, then a back-to-back halt.
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("single_halt_no_err", 32'(hz_err), 32'd0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("double_halt_err_sticky", 32'(hz_err), 32'd1);
        do_reset();

        // D-cache wait masking a halt; bubble on release.
        repeat (4) cyc(1, 0, 1, 0);
        chk("mem_wait_state", 32'(ctrl_state), 32'd1);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // Redirect, plain and with a D-cache stall inside FLUSH.
        cyc(0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        repeat (3) cyc(0, 0, 1, 0);
        chk("flush_held_by_dcache", 32'(ctrl_state), 32'd2);
        repeat (3) cyc(0, 0, 0, 0);

        // Redirect beats I-cache stall; reset in the middle of FLUSH.
        FW_halt = 0; icache_stall = 1; dcache_stall = 0; br_mispredict = 1;
        #1 chk("redirect_over_icache_pc_en", 32'(pc_en), 32'd1);
        cyc(0, 1, 0, 1);
        chk("flush_entered", 32'(ctrl_state), 32'd2);
        do_reset();

`ifdef RENAS_STALL_CNT_EN
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
        repeat (10) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 1);
            repeat (3) cyc(0, 0, 0, 0);
        end
        chk("bubble_cnt_3", 32'(bubble_cnt), 32'd3);
        chk("stall_cnt_10", 32'(stall_cnt), 32'd10);
        chk("flush_cnt_perf_2", 32'(flush_cnt_perf), 32'd2);
        do_reset();
        repeat (20) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("stall_cnt_sat", 32'(stall_cnt), 32'd15);
        do_reset();
`endif

        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 20),
                    ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
